fetch_arbiter: RTL and testbench

Shares one external memory read port among the three stream fetchers: value, column and length. The fetchers are packed in requester order 0=value, 1=column, 2=length. Each requester asks for a burst (address plus beat count). The arbiter grants bursts round-robin, issues each one to memory, and routes the returned beats back to the owning fetcher's FIFO fill path. It sits between the fetchers and the memory interface, below top.

---
 rtl/fetch_arbiter_pkg.sv | 28 ++
 rtl/fetch_arbiter_rr_pick.sv | 32 +++
 rtl/fetch_arbiter.sv | 149 ++++++++++++++
 tb/tb_fetch_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_arbiter_pkg.sv
// Shared sizes, requester indices and FSM encodings for the stream fetch arbiter.
// Imported by the arbiter top and its round-robin picker.
package fetch_arbiter_pkg;

    localparam int NUM_REQ    = 3;
    localparam int ADDR_BITS  = 32;
    localparam int DATA_BITS  = 64;
    localparam int BURST_BITS = 4;

    localparam int REQ_VAL = 0;
    localparam int REQ_COL = 1;
    localparam int REQ_LEN = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Pointer width that still works for a single requester.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Distance from ptr forward to idx on a ring of n slots.
    function automatic int ring_dist(input int idx, input int ptr, input int n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap
// at num_req rather than at a power of two.
module fetch_arbiter_rr_pick
    import fetch_arbiter_pkg::*;
#(
    parameter int num_req  = NUM_REQ,
    parameter int ptr_bits = ptr_width(NUM_REQ)
) (
    input  logic [num_req-1:0]  req,
    input  logic [ptr_bits-1:0] rr_ptr,
    output logic [ptr_bits-1:0] grant,
    output logic                any_req
);

    int   best_s;
    logic take_s;

    // Keep the requester with the smallest forward distance from rr_ptr.
    always_comb begin
        best_s = num_req;
        take_s = 1'b0;
        grant  = {ptr_bits{1'b0}};
        for (int j = 0; j < num_req; j++) begin
            take_s = req[j] && (ring_dist(j, int'(rr_ptr), num_req) < best_s);
            best_s = take_s ? ring_dist(j, int'(rr_ptr), num_req) : best_s;
            grant  = take_s ? ptr_bits'(j) : grant;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fetch_arbiter.sv
// Shares one memory read port among the value/column/length fetchers: round-robin
// burst grant, command issue, and zero-latency routing of read beats to the owner.
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int num_req    = NUM_REQ,
    parameter int addr_bits  = ADDR_BITS,
    parameter int data_bits  = DATA_BITS,
    parameter int burst_bits = BURST_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [num_req-1:0]              req,
    input  logic [addr_bits*num_req-1:0]    req_addr,
    input  logic [burst_bits*num_req-1:0]   req_len,
    output logic [num_req-1:0]              req_ack,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [addr_bits-1:0]            mem_req_addr,
    output logic [burst_bits-1:0]           mem_req_len,
    input  logic                            mem_resp_valid,
    input  logic [data_bits-1:0]            mem_resp_data,
    output logic                            mem_resp_ready,
    output logic [data_bits-1:0]            rd_data,
    output logic [num_req-1:0]              rd_valid,
    input  logic [num_req-1:0]              rd_ready,
    output logic                            rd_last,
    output logic                            busy,
    output logic                            err
);

    localparam int PTR_BITS = ptr_width(num_req);

    logic [1:0]            state_r;
    logic [PTR_BITS-1:0]   rr_ptr_r;
    logic [PTR_BITS-1:0]   grant_r;
    logic [burst_bits-1:0] beat_cnt_r;
    logic [addr_bits-1:0]  addr_r;
    logic [burst_bits-1:0] len_r;
    logic                  err_r;

    logic [PTR_BITS-1:0]   pick_s;
    logic                  any_req_s;
    logic                  xfer_s;
    logic [PTR_BITS-1:0]   next_ptr_s;
    logic [addr_bits-1:0]  addr_arr_s [num_req];
    logic [burst_bits-1:0] len_arr_s  [num_req];

    for (genvar i = 0; i < num_req; i++) begin : g_unpack
        assign addr_arr_s[i] = req_addr[i*addr_bits +: addr_bits];
        assign len_arr_s[i]  = req_len[i*burst_bits +: burst_bits];
    end

    fetch_arbiter_rr_pick #(
        .num_req  (num_req),
        .ptr_bits (PTR_BITS)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_r),
        .grant   (pick_s),
        .any_req (any_req_s)
    );

    assign xfer_s     = (state_r == ST_STREAM) && mem_resp_valid && rd_ready[grant_r];
    assign next_ptr_s = (grant_r == PTR_BITS'(num_req - 1)) ? {PTR_BITS{1'b0}}
                                                            : grant_r + PTR_BITS'(1);

    // Burst FSM with grant, address and length latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {PTR_BITS{1'b0}};
            grant_r    <= {PTR_BITS{1'b0}};
            beat_cnt_r <= {burst_bits{1'b0}};
            addr_r     <= {addr_bits{1'b0}};
            len_r      <= {burst_bits{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r    <= pick_s;
                        addr_r     <= addr_arr_s[pick_s];
                        len_r      <= len_arr_s[pick_s];
                        beat_cnt_r <= {burst_bits{1'b0}};
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready) begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer_s) begin
                        if (beat_cnt_r == len_r) begin
                            rr_ptr_r <= next_ptr_s;
                            state_r  <= ST_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + burst_bits'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky flag for beats arriving with no burst open; such beats are left unconsumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((state_r != ST_STREAM) && mem_resp_valid) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Handshake decode; ack and beat routing are combinational to avoid added latency.
    always_comb begin
        req_ack        = {num_req{1'b0}};
        rd_valid       = {num_req{1'b0}};
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        rd_last        = 1'b0;
        case (state_r)
            ST_ISSUE: begin
                mem_req_valid    = 1'b1;
                req_ack[grant_r] = mem_req_ready;
            end
            ST_STREAM: begin
                rd_valid[grant_r] = mem_resp_valid;
                mem_resp_ready    = rd_ready[grant_r];
                rd_last           = mem_resp_valid && (beat_cnt_r == len_r);
            end
            default: begin
            end
        endcase
    end

    assign mem_req_addr = addr_r;
    assign mem_req_len  = len_r;
    assign rd_data      = mem_resp_data;
    assign busy         = (state_r != ST_IDLE);
    assign err          = err_r;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: directed scenarios with literal expectations plus a random
// run, all cross-checked every cycle against a transaction-level reference model.
module tb_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [31:0] a_arr [3];
    logic [3:0]  l_arr [3];
    logic [95:0] req_addr;
    logic [11:0] req_len;
    logic [2:0]  req_ack;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_len;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        mem_resp_ready;
    logic [63:0] rd_data;
    logic [2:0]  rd_valid;
    logic [2:0]  rd_ready;
    logic        rd_last;
    logic        busy;
    logic        err;

    assign req_addr = {a_arr[2], a_arr[1], a_arr[0]};
    assign req_len  = {l_arr[2], l_arr[1], l_arr[0]};

    always #5 clk = ~clk;

    fetch_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .req_ack        (req_ack),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_len    (mem_req_len),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_ready (mem_resp_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_last        (rd_last),
        .busy           (busy),
        .err            (err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: phase 0 idle, 1 command pending, 2 beats flowing.
    int          m_ph    = 0;
    int          m_own   = 0;
    int          m_cnt   = 0;
    int          m_len   = 0;
    int          m_ptr   = 0;
    logic [31:0] m_addr  = 32'h0;
    bit          m_err   = 1'b0;
    bit          m_valid = 1'b0;
    logic [2:0]  m_ack   = 3'b000;

    logic [63:0] got [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Compare process: expected outputs from the model, then advance the model.
    initial begin
        logic [2:0] e_ack, e_rdv;
        logic       e_mrr, e_last;
        int         j;
        bit         found;
        forever begin
            @(negedge clk);
            e_ack  = (m_ph == 1 && mem_req_ready) ? 3'(1 << m_own) : 3'b000;
            e_rdv  = (m_ph == 2 && mem_resp_valid) ? 3'(1 << m_own) : 3'b000;
            e_mrr  = (m_ph == 2) ? rd_ready[m_own] : 1'b0;
            e_last = (m_ph == 2) && mem_resp_valid && (m_cnt == m_len);
            if (m_valid) begin
                chk("busy",           64'(busy),           64'(m_ph != 0));
                chk("mem_req_valid",  64'(mem_req_valid),  64'(m_ph == 1));
                chk("mem_req_addr",   64'(mem_req_addr),   64'(m_addr));
                chk("mem_req_len",    64'(mem_req_len),    64'(m_len));
                chk("req_ack",        64'(req_ack),        64'(e_ack));
                chk("rd_valid",       64'(rd_valid),       64'(e_rdv));
                chk("mem_resp_ready", 64'(mem_resp_ready), 64'(e_mrr));
                chk("rd_last",        64'(rd_last),        64'(e_last));
                chk("rd_data",        rd_data,             mem_resp_data);
                chk("err",            64'(err),            64'(m_err));
            end
            m_ack = e_ack;
            if (rst) begin
                m_ph = 0; m_own = 0; m_cnt = 0; m_len = 0; m_ptr = 0;
                m_addr = 32'h0; m_err = 1'b0; m_valid = 1'b1;
            end else if (m_valid) begin
                if (m_ph != 2 && mem_resp_valid) m_err = 1'b1;
                case (m_ph)
                    0: begin
                        found = 1'b0;
                        for (int k = 0; k < 3; k++) begin
                            j = (m_ptr + k) % 3;
                            if (!found && req[j]) begin
                                found = 1'b1;
                                m_own = j;
                            end
                        end
                        if (found) begin
                            m_addr = a_arr[m_own];
                            m_len  = int'(l_arr[m_own]);
                            m_cnt  = 0;
                            m_ph   = 1;
                        end
                    end
                    1: if (mem_req_ready) m_ph = 2;
                    default: begin
                        if (mem_resp_valid && rd_ready[m_own]) begin
                            if (m_cnt == m_len) begin
                                m_ptr = (m_own + 1) % 3;
                                m_ph  = 0;
                            end else begin
                                m_cnt++;
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic wait_ack(input int idx, output int w, output logic [31:0] ca, output logic [3:0] cl);
        w = -1; ca = 32'h0; cl = 4'h0;
        for (int c = 0; c < 20 && w < 0; c++) begin
            @(negedge clk);
            if (req_ack[idx]) begin
                w  = c;
                ca = mem_req_addr;
                cl = mem_req_len;
            end
            step();
        end
    endtask

    task automatic stream(input int n, input logic [63:0] base,
                          output int nv, output int nl, output int lp, output int nack);
        int k = 0;
        nv = 0; nl = 0; lp = -1; nack = 0;
        got.delete();
        mem_resp_valid = 1'b1;
        mem_resp_data  = base;
        for (int c = 0; c < 80 && k < n; c++) begin
            @(negedge clk);
            if (rd_valid != 3'b000) nv++;
            if (req_ack != 3'b000) nack++;
            if (rd_last) begin nl++; lp = k; end
            if (mem_resp_valid && mem_resp_ready) begin
                got.push_back(rd_data);
                k++;
            end
            step();
            mem_resp_data = base + 64'(k);
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        req = 3'b000;
        mem_resp_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, nv, nl, lp, nack, k;
        logic [31:0] ca;
        logic [3:0]  cl;
        int          order [$];
        int          acyc  [$];

        rst = 1'b1; req = 3'b000; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = 64'h0; rd_ready = 3'b111;
        for (int i = 0; i < 3; i++) begin a_arr[i] = 32'h0; l_arr[i] = 4'h0; end
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_err",  64'(err),  64'd0);
        chk("reset_addr", 64'(mem_req_addr), 64'd0);
        step();

        // Single 4-beat burst for the value fetcher.
        a_arr[0] = 32'h100; l_arr[0] = 4'd3; req = 3'b001; mem_req_ready = 1'b1;
        wait_ack(0, w, ca, cl);
        req = 3'b000;
        chk("t1_ack_seen", 64'(w >= 0), 64'd1);
        chk("t1_addr", 64'(ca), 64'h100);
        chk("t1_len",  64'(cl), 64'd3);
        stream(4, 64'hD0, nv, nl, lp, nack);
        chk("t1_valid_cnt", 64'(nv), 64'd4);
        chk("t1_last_cnt",  64'(nl), 64'd1);
        chk("t1_last_pos",  64'(lp), 64'd3);
        chk("t1_extra_ack", 64'(nack), 64'd0);
        chk("t1_beat3", (got.size() == 4) ? got[3] : 64'hdead, 64'hD3);
        @(negedge clk);
        chk("t1_idle", 64'(busy), 64'd0);
        step();

        // Round-robin with everyone requesting one-beat bursts.
        do_reset();
        for (int i = 0; i < 3; i++) begin a_arr[i] = 32'h40 * (i + 1); l_arr[i] = 4'd0; end
        req = 3'b111;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (req_ack[i]) begin order.push_back(i); acyc.push_back(cyc); end
            end
            step();
            mem_resp_valid = (m_ph == 2);
        end
        chk("rr_count", 64'(order.size()), 64'd4);
        if (order.size() == 4) begin
            chk("rr_g0", 64'(order[0]), 64'd0);
            chk("rr_g1", 64'(order[1]), 64'd1);
            chk("rr_g2", 64'(order[2]), 64'd2);
            chk("rr_g3", 64'(order[3]), 64'd0);
            chk("rr_gap", 64'(acyc[3] - acyc[2]), 64'd3);
        end
        do_reset();

        // Owner backpressure on a two-beat burst.
        a_arr[1] = 32'h3000; l_arr[1] = 4'd1; req = 3'b010;
        wait_ack(1, w, ca, cl);
        req = 3'b000;
        chk("bp_ack_seen", 64'(w >= 0), 64'd1);
        rd_ready = 3'b101; mem_resp_valid = 1'b1; mem_resp_data = 64'hA0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_resp_ready", 64'(mem_resp_ready), 64'd0);
            chk("bp_rd_valid",   64'(rd_valid), 64'd2);
            chk("bp_no_last",    64'(rd_last), 64'd0);
            step();
        end
        rd_ready = 3'b111;
        stream(2, 64'hA0, nv, nl, lp, nack);
        chk("bp_beats", 64'(got.size()), 64'd2);
        chk("bp_beat0", (got.size() == 2) ? got[0] : 64'hdead, 64'hA0);
        chk("bp_beat1", (got.size() == 2) ? got[1] : 64'hdead, 64'hA1);
        chk("bp_last_pos", 64'(lp), 64'd1);

        // Command stall: issue held for five cycles.
        do_reset();
        a_arr[2] = 32'h2000; l_arr[2] = 4'd5; mem_req_ready = 1'b0; req = 3'b100;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("cs_valid", 64'(mem_req_valid), 64'd1);
            chk("cs_addr",  64'(mem_req_addr), 64'h2000);
            chk("cs_len",   64'(mem_req_len), 64'd5);
            chk("cs_no_ack", 64'(req_ack), 64'd0);
            step();
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("cs_ack", 64'(req_ack), 64'd4);
        step();
        req = 3'b000;
        stream(6, 64'h50, nv, nl, lp, nack);
        chk("cs_last_pos", 64'(lp), 64'd5);

        // Stray beat while idle.
        do_reset();
        mem_resp_valid = 1'b1;
        @(negedge clk);
        chk("sb_resp_ready", 64'(mem_resp_ready), 64'd0);
        chk("sb_rd_valid",   64'(rd_valid), 64'd0);
        step();
        mem_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("sb_err_sticky", 64'(err), 64'd1);
            step();
        end
        chk("sb_model_err", 64'(m_err), 64'd1);
        do_reset();
        @(negedge clk);
        chk("sb_err_cleared", 64'(err), 64'd0);
        step();

        // Reset on beat 2 of an 8-beat burst, then a fresh grant to requester 2.
        a_arr[0] = 32'h700; l_arr[0] = 4'd7; req = 3'b001;
        wait_ack(0, w, ca, cl);
        req = 3'b000;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h70; k = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            @(negedge clk);
            if (mem_resp_valid && mem_resp_ready) k++;
            step();
            mem_resp_data = 64'h70 + 64'(k);
        end
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("mr_busy",     64'(busy), 64'd0);
        chk("mr_rd_valid", 64'(rd_valid), 64'd0);
        chk("mr_rd_last",  64'(rd_last), 64'd0);
        chk("mr_ready",    64'(mem_resp_ready), 64'd0);
        step();
        rst = 1'b0; mem_resp_valid = 1'b0;
        a_arr[2] = 32'h900; l_arr[2] = 4'd0; req = 3'b100;
        wait_ack(2, w, ca, cl);
        req = 3'b000;
        chk("mr_regrant", 64'(w >= 0), 64'd1);
        chk("mr_addr", 64'(ca), 64'h900);
        stream(1, 64'h90, nv, nl, lp, nack);
        chk("mr_last", 64'(nl), 64'd1);

        // Randomized traffic, checked by the compare process every cycle.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            mem_req_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) rd_ready[i] = ($urandom_range(0, 3) != 0);
            mem_resp_valid = (m_ph == 2) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 199) == 0);
            mem_resp_data = {$urandom, $urandom};
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        a_arr[i] = $urandom;
                        l_arr[i] = 4'($urandom_range(0, 15));
                    end
                end else if (m_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        a_arr[i] = $urandom;
                        l_arr[i] = 4'($urandom_range(0, 15));
                    end
                end
            end
            step();
        end
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
